// File: rtl/hex_pio_arbiter.sv
// ============================================================================
//  Module   : hex_pio_arbiter
//  Purpose  : Round-robin arbiter that shares a two-digit HEX display PIO
//             between two requesters. It encodes the winning byte into two
//             active-low 7-segment digits and issues one Avalon-MM write.
//             A hold timer enforces a minimum spacing between writes.
//  Options  : HEX_READBACK_EN - after each write, read the PIO back and set
//             a sticky err flag if the readback does not match.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_pio_arbiter #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [1:0] PIO_ADDR    = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [7:0]  val0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  val1,
    output logic        ack1,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        err
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Active-low segments, bit0 = a .. bit6 = g, bit7 (dp) always 0
    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h40;  4'h1: s = 8'h79;  4'h2: s = 8'h24;  4'h3: s = 8'h30;
            4'h4: s = 8'h19;  4'h5: s = 8'h12;  4'h6: s = 8'h02;  4'h7: s = 8'h78;
            4'h8: s = 8'h00;  4'h9: s = 8'h10;  4'hA: s = 8'h08;  4'hB: s = 8'h03;
            4'hC: s = 8'h46;  4'hD: s = 8'h21;  4'hE: s = 8'h06;  default: s = 8'h0E;
        endcase
        return s;
    endfunction

    state_t            state_q;
    logic              last_grant_q;
    logic              winner_q;
    logic [HOLD_W-1:0] hold_q;
    logic              cs_q;
    logic              wn_q;
    logic [1:0]        addr_q;
    logic [31:0]       wd_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              err_q;

    logic              grant_valid_d;
    logic              grant_sel_d;
    logic [7:0]        val_sel_d;

`ifdef HEX_READBACK_EN
    logic [15:0]       rd_q;
    logic [15:0]       unused_rd_hi;
    assign unused_rd_hi = avm_readdata[31:16];
`else
    logic [31:0]       unused_rd;
    assign unused_rd = avm_readdata;
`endif

    // Round-robin pick: on contention the requester that did not win last
    always_comb begin
        grant_valid_d = (hold_q == '0) && (req0 || req1);
        grant_sel_d   = (req0 && req1) ? ~last_grant_q : req1;
        val_sel_d     = grant_sel_d ? val1 : val0;
    end

    // Arbitration FSM with registered bus and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            hold_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 2'd0;
            wd_q         <= 32'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef HEX_READBACK_EN
            rd_q         <= 16'd0;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end else if (grant_valid_d) begin
                        winner_q <= grant_sel_d;
                        wd_q     <= {16'h0000, seg_enc(val_sel_d[7:4]), seg_enc(val_sel_d[3:0])};
                        cs_q     <= 1'b1;
                        wn_q     <= 1'b0;
                        addr_q   <= PIO_ADDR;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef HEX_READBACK_EN
                    // Keep chipselect for the readback cycle, drop the strobe
                    wn_q    <= 1'b1;
                    state_q <= S_READ;
`else
                    cs_q    <= 1'b0;
                    wn_q    <= 1'b1;
                    ack0_q  <= ~winner_q;
                    ack1_q  <= winner_q;
                    state_q <= S_ACK;
`endif
                end
`ifdef HEX_READBACK_EN
                S_READ: begin
                    rd_q    <= avm_readdata[15:0];
                    cs_q    <= 1'b0;
                    ack0_q  <= ~winner_q;
                    ack1_q  <= winner_q;
                    state_q <= S_ACK;
                end
`endif
                S_ACK: begin
                    last_grant_q <= winner_q;
                    hold_q       <= HOLD_W'(HOLD_CYCLES);
`ifdef HEX_READBACK_EN
                    if (rd_q != wd_q[15:0]) begin
                        err_q <= 1'b1;
                    end
`endif
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wd_q;
    assign busy           = (state_q != S_IDLE) || (hold_q != '0);
    assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_pio_arbiter.sv
// ============================================================================
//  Module   : tb_hex_pio_arbiter
//  Purpose  : Self-checking bench for hex_pio_arbiter. Two instances (hold 4
//             and hold 0) share the requester stimulus; a transaction-level
//             timing model predicts every output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_pio_arbiter;

`ifdef HEX_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam logic [1:0] C_ADDR = 2'd0;
    localparam logic [7:0] C_SEG [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                          8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
    localparam int C_HOLD [2] = '{4, 0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  val0 = 8'h00, val1 = 8'h00;
    logic        corrupt = 1'b0;

    logic [1:0]  ack0_o, ack1_o, cs_o, wn_o, busy_o, err_o;
    logic [1:0]  addr_o [2];
    logic [31:0] wd_o [2];
    logic [31:0] rdata [2];
    logic [15:0] pio [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state per instance
    int          m_last [2];
    int          m_next [2];
    int          m_g    [2];
    int          m_win  [2];
    logic [31:0] m_wd   [2];
    logic        m_err  [2];

    // Requester behaviour: 0 = hold levels, 1 = drop on ack, optional random raises
    int agent = 0;
    int raise_en = 0;

    always #5 clk = ~clk;

    hex_pio_arbiter #(.HOLD_CYCLES(4), .PIO_ADDR(C_ADDR)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .val0(val0), .ack0(ack0_o[0]),
        .req1(req1), .val1(val1), .ack1(ack1_o[0]),
        .avm_address(addr_o[0]), .avm_chipselect(cs_o[0]), .avm_write_n(wn_o[0]),
        .avm_writedata(wd_o[0]), .avm_readdata(rdata[0]),
        .busy(busy_o[0]), .err(err_o[0]));

    hex_pio_arbiter #(.HOLD_CYCLES(0), .PIO_ADDR(C_ADDR)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .val0(val0), .ack0(ack0_o[1]),
        .req1(req1), .val1(val1), .ack1(ack1_o[1]),
        .avm_address(addr_o[1]), .avm_chipselect(cs_o[1]), .avm_write_n(wn_o[1]),
        .avm_writedata(wd_o[1]), .avm_readdata(rdata[1]),
        .busy(busy_o[1]), .err(err_o[1]));

    // PIO slave models: store written data, combinational readback
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio[0] <= 16'h4040;
        else if (cs_o[0] && !wn_o[0]) pio[0] <= wd_o[0][15:0];
    end
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio[1] <= 16'h4040;
        else if (cs_o[1] && !wn_o[1]) pio[1] <= wd_o[1][15:0];
    end
    assign rdata[0] = {16'h0000, pio[0] ^ {15'h0, corrupt}};
    assign rdata[1] = {16'h0000, pio[1] ^ {15'h0, corrupt}};

    function automatic logic [31:0] hex_word(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = v[7:4];
        lo = v[3:0];
        return {16'h0000, C_SEG[hi], C_SEG[lo]};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_last[d] = 1;
        m_next[d] = 0;
        m_g[d]    = -100;
        m_win[d]  = 0;
        m_wd[d]   = 32'd0;
        m_err[d]  = 1'b0;
    endtask

    // Transaction view: a grant at edge g strobes after g, acks after g+1+RB,
    // and blocks the next grant until edge g+3+RB+hold.
    task automatic model_edge(input int d);
        int w;
        if (!reset_n) begin
            model_reset(d);
            return;
        end
        if (RB == 1 && cyc == m_g[d] + 3 && corrupt) m_err[d] = 1'b1;
        if (cyc >= m_next[d] && (req0 || req1)) begin
            if (req0 && req1) w = 1 - m_last[d];
            else              w = req0 ? 0 : 1;
            m_g[d]    = cyc;
            m_win[d]  = w;
            m_last[d] = w;
            m_wd[d]   = hex_word(w == 0 ? val0 : val1);
            m_next[d] = cyc + 3 + RB + C_HOLD[d];
        end
    endtask

    task automatic check_outputs(input int d);
        logic cs_e, wn_e, a0_e, a1_e, busy_e;
        int   g;
        g      = m_g[d];
        cs_e   = (cyc == g) || (RB == 1 && cyc == g + 1);
        wn_e   = !(cyc == g);
        a0_e   = (cyc == g + 1 + RB) && (m_win[d] == 0);
        a1_e   = (cyc == g + 1 + RB) && (m_win[d] == 1);
        busy_e = (cyc >= g) && (cyc < g + 2 + RB + C_HOLD[d]);
        chk("chipselect", d, {31'd0, cs_o[d]}, {31'd0, cs_e});
        chk("write_n",    d, {31'd0, wn_o[d]}, {31'd0, wn_e});
        chk("writedata",  d, wd_o[d], m_wd[d]);
        chk("ack0",       d, {31'd0, ack0_o[d]}, {31'd0, a0_e});
        chk("ack1",       d, {31'd0, ack1_o[d]}, {31'd0, a1_e});
        chk("busy",       d, {31'd0, busy_o[d]}, {31'd0, busy_e});
        chk("err",        d, {31'd0, err_o[d]}, {31'd0, m_err[d]});
        if (cs_e) chk("address", d, {30'd0, addr_o[d]}, {30'd0, C_ADDR});
    endtask

    // One clock: advance model on the edge, check 1 ns later, then update requesters
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs(0);
        check_outputs(1);
        if (agent == 1) begin
            if (ack0_o[0]) req0 = 1'b0;
            else if (!req0 && raise_en == 1 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                val0 = 8'($urandom);
            end else if (req0 && $urandom_range(0, 3) == 0) val0 = 8'($urandom);
            if (ack1_o[0]) req1 = 1'b0;
            else if (!req1 && raise_en == 1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                val1 = 8'($urandom);
            end else if (req1 && $urandom_range(0, 3) == 0) val1 = 8'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset values, then a quiet period with no bus activity
        run(3);
        #2 reset_n = 1'b1;
        run(12);

        // Single request from requester 0: 0x3A -> 0x3008
        agent = 1; raise_en = 0;
        req0 = 1'b1; val0 = 8'h3A;
        run(12);

        // Contention with both requests held: alternating grants
        agent = 0;
        req0 = 1'b1; val0 = 8'h00;
        req1 = 1'b1; val1 = 8'hFF;
        run(40);

        // Only requester 1 held: spacing set by the hold timer
        req0 = 1'b0;
        run(30);
        req1 = 1'b0;
        run(10);

        // Randomised requesters with value changes while pending
        agent = 1; raise_en = 1;
        run(600);
        raise_en = 0;
        run(15);

        // Reset during the write strobe: strobe cut at once, no ack
        agent = 0;
        req1 = 1'b0;
        req0 = 1'b1; val0 = 8'h5C;
        for (int i = 0; i < 12 && cs_o[0] !== 1'b1; i++) tick();
        chk("strobe_before_reset", 0, {31'd0, cs_o[0]}, 32'd1);
        #2 reset_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_outputs(0);
        check_outputs(1);
        run(2);
        #2 reset_n = 1'b1;
        agent = 1;
        run(12);

        // Readback with a corrupted slave, then a clean one
        corrupt = 1'b1;
        req1 = 1'b1; val1 = 8'h7E;
        run(14);
        corrupt = 1'b0;
        req0 = 1'b1; val0 = 8'hB4;
        run(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hex_pio_arbiter.md
Name: hex_pio_arbiter

Overview:
- Shares one 16-bit HEX display PIO slave (two digits, e.g. HEX5/HEX4) between two requesters.
- Each requester submits an 8-bit value. The block round-robin arbitrates between them.
- The winning value is encoded into two active-low 7-segment bytes and written to the PIO with a single Avalon-MM write.
- Successive writes are rate-limited by a hold timer.
- Sits between fabric logic (counters, status sources) and the HEX PIO's s1 slave port.

Parameters:
- HOLD_CYCLES, 4: minimum idle cycles after an ack before the next grant; 0 = back-to-back allowed; counter width = clog2(HOLD_CYCLES+1), minimum 1.
- PIO_ADDR, 0: register offset driven on avm_address for data writes and reads.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request, level; held until ack0
- val0  in  8  requester 0 value; high nibble -> upper digit
- ack0  out  1  one-cycle pulse; requester 0 write complete
- req1  in  1  requester 1 request, level
- val1  in  8  requester 1 value
- ack1  out  1  one-cycle pulse; requester 1 write complete
- avm_address  out  2  PIO register address
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  PIO write data
- avm_readdata  in  32  PIO read data (combinational in slave)
- busy  out  1  high in any state other than IDLE, or while the hold counter is nonzero
- err  out  1  sticky readback mismatch (HEX_READBACK_EN only; else tied 0)

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE; avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - ack0=ack1=0, busy=0, err=0, hold counter=0.
  - last_grant=1, so requester 0 has priority first.
  - No write is issued at reset; the PIO keeps its own reset pattern 0x4040 ("00").
- Encoding: active-low, bit0=a .. bit6=g, bit7=0.
  - 0..9 -> 40 79 24 30 19 12 02 78 00 10
  - A..F -> 08 03 46 21 06 0E
  - writedata = {16'h0, enc(val[7:4]), enc(val[3:0])}.
- State IDLE:
  - Grant requires hold counter == 0 and at least one req.
  - Both req: grant the requester not equal to last_grant.
  - One req: grant it.
  - On grant, latch the winner's val, register writedata, and go to WRITE.
  - Hold counter decrements by 1 per cycle while nonzero.
- State WRITE: exactly one cycle with avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR. Next state is ACK, or READ when readback is enabled.
- State ACK: pulse ack of the granted requester for one cycle; set last_grant=winner; load hold counter=HOLD_CYCLES; return to IDLE.
- Latency:
  - req sampled high in IDLE at cycle T -> write strobe at T+1 -> ack at T+2.
  - With HOLD_CYCLES=H, the earliest next grant is at T+3+H.
- Requester protocol:
  - Requester drops req in the cycle after ack; req still high at the next IDLE is a new request.
  - val is sampled only in the grant cycle; later changes are ignored.
  - Dropping req before ack does not abort the write; ack is still pulsed.
- Outside WRITE/READ: avm_chipselect=0, avm_write_n=1; avm_writedata holds its last value.
- Mid-operation reset: immediate return to reset values; any in-flight write strobe is cut, and no ack is issued.

Optional Feature:
- Macro: HEX_READBACK_EN.
- Defined:
  - After WRITE, enter READ for one cycle: avm_chipselect=1, avm_write_n=1, avm_address=PIO_ADDR.
  - avm_readdata[15:0] is registered at the end of READ.
  - In ACK, if it differs from writedata[15:0], err sets. err stays high until reset.
  - Ack latency becomes T+3.
- Undefined: no READ state; avm_readdata is ignored; err is constant 0.

Test Plan:
- Reset: reset_n low then high -> all outputs at reset values; no chipselect within 10 cycles; busy=0.
- Single request: req0=1, val0=8'h3A, HOLD_CYCLES=4 -> one write with writedata=32'h0000_3008 at T+1; ack0 pulse at T+2; busy high until T+6.
- Contention: req0 and req1 both held with val0=8'h00 and val1=8'hFF -> grant order 0, 1, 0, 1; writedata alternates 0x4040 and 0x0E0E; acks alternate; exactly one chipselect per ack.
- Hold limit: HOLD_CYCLES=0 with req1 held continuously -> a write every 3 cycles. HOLD_CYCLES=4 -> a write every 7 cycles.
- Mid-operation reset: reset_n asserted during WRITE -> chipselect drops asynchronously; no ack. After release, a pending req0 is served normally.
- Readback (HEX_READBACK_EN defined):
  - Slave model corrupts readdata bit 0 -> err=1 after the ack, and stays 1.
  - Correct model -> err stays 0; ack at T+3.
